// File: rtl/rvv_cfg_pkg.sv
// Shared encodings for the vector configuration unit (vcfg_unit).
// Holds the vset* instruction type and AVL-mode encodings, the FSM state
// enum, the SEW/LMUL encodings the legality check needs, the vtype field
// offsets, and a helper that decodes fractional LMUL.
package rvv_cfg_pkg;

    // Which vset* flavour issued the request; 01 behaves as vsetvli.
    typedef enum logic [1:0] {
        CFG_VSETVLI  = 2'b00,
        CFG_RSVD     = 2'b01,
        CFG_VSETVL   = 2'b10,
        CFG_VSETIVLI = 2'b11
    } cfg_type_e;

    // AVL source. Bit 1 set means "keep the current vl" (rs1 = rd = x0).
    localparam logic [1:0] AVL_USE_IN   = 2'b00;
    localparam logic [1:0] AVL_USE_MAX  = 2'b01;
    localparam int         AVL_KEEP_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CALC   = 2'b01,
        ST_COMMIT = 2'b10,
        ST_RESP   = 2'b11
    } state_e;

    localparam logic [2:0] SEW_64    = 3'b011;
    localparam logic [2:0] LMUL_1    = 3'b000;
    localparam logic [2:0] LMUL_RSVD = 3'b100;

    // vtype field positions
    localparam int VTYPE_VLMUL_LSB = 0;
    localparam int VTYPE_VSEW_LSB  = 3;
    localparam int VTYPE_VTA_BIT   = 6;
    localparam int VTYPE_VMA_BIT   = 7;
    localparam int VTYPE_RSVD_LSB  = 8;

    // log2 of the LMUL divisor for fractional settings (1/8 -> 3, 1/4 -> 2,
    // 1/2 -> 1); integral and reserved encodings return 0.
    function automatic logic [2:0] lmul_frac_log2(input logic [2:0] vlmul);
        logic [2:0] r;
        case (vlmul)
            3'b101:  r = 3'd3;
            3'b110:  r = 3'd2;
            3'b111:  r = 3'd1;
            default: r = 3'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vcfg_unit_if.sv
// Bus bundle of the vector configuration unit.
// slave  : the unit's view (request in, CSRs and writeback out).
// master : the decoder / writeback / lane side.
// Request: in_valid/in_ready, flush, cfg_type, avl_mode, avl_in, vtype_in.
// CSRs   : vl, vsew, vlmul, vta, vma, vill, new_vl.
// Writeback: wb_valid/wb_ready, wb_data.
interface vcfg_unit_if #(
    parameter int XLEN    = 32,
    parameter int VL_BITS = 15
);
    logic               in_valid;
    logic               in_ready;
    logic               flush;
    logic [1:0]         cfg_type;
    logic [1:0]         avl_mode;
    logic [XLEN-1:0]    avl_in;
    logic [XLEN-1:0]    vtype_in;
    logic [VL_BITS-1:0] vl;
    logic [2:0]         vsew;
    logic [2:0]         vlmul;
    logic               vta;
    logic               vma;
    logic               vill;
    logic               new_vl;
    logic               wb_valid;
    logic               wb_ready;
    logic [XLEN-1:0]    wb_data;

    modport slave (
        input  in_valid, flush, cfg_type, avl_mode, avl_in, vtype_in, wb_ready,
        output in_ready, vl, vsew, vlmul, vta, vma, vill, new_vl, wb_valid, wb_data
    );

    modport master (
        output in_valid, flush, cfg_type, avl_mode, avl_in, vtype_in, wb_ready,
        input  in_ready, vl, vsew, vlmul, vta, vma, vill, new_vl, wb_valid, wb_data
    );
endinterface

// File: rtl/vlmax_calc.sv
// Combinational VLMAX and vtype legality.
// Inputs : vsew, vlmul (vtype fields), rsvd_nz (reserved vtype bits nonzero).
// Outputs: vlmax = VLEN >> (3 + vsew - signed(vlmul)), illegal flag.
// Macro RVV_LMUL_EN: when defined the full LMUL range 1/8..8 is legal;
// otherwise only LMUL=1 is accepted and the shift is 3 + vsew.
module vlmax_calc
    import rvv_cfg_pkg::*;
#(
    parameter int VLEN          = 16384,
    parameter int VL_BITS       = $clog2(VLEN) + 1,
    parameter bit ENABLE_64_BIT = 1'b1
) (
    input  logic [2:0]         vsew,
    input  logic [2:0]         vlmul,
    input  logic               rsvd_nz,
    output logic [VL_BITS-1:0] vlmax,
    output logic               illegal
);

    localparam logic [VL_BITS-1:0] VLEN_V = VL_BITS'(VLEN);
    // log2(ELEN) - 3, i.e. the largest legal vsew encoding
    localparam logic [2:0] ELEN_LOG2_M3 = ENABLE_64_BIT ? 3'd3 : 3'd2;

    logic [4:0] shift_s;
    logic       sew_bad_s;
    logic       lmul_bad_s;
    logic       ratio_bad_s;

    // Shift amount, VLMAX and each legality term
    always_comb begin
        shift_s     = 5'd3 + {2'b00, vsew};
        lmul_bad_s  = 1'b0;
        ratio_bad_s = 1'b0;
`ifdef RVV_LMUL_EN
        // Subtract signed LMUL exponent; the minimum result is 0, so the
        // shift never goes negative.
        shift_s    = shift_s - {{2{vlmul[2]}}, vlmul};
        lmul_bad_s = (vlmul == LMUL_RSVD);
        // Fractional LMUL must satisfy LMUL >= SEW/ELEN.
        ratio_bad_s = ({1'b0, vsew} + {1'b0, lmul_frac_log2(vlmul)}) > {1'b0, ELEN_LOG2_M3};
`else
        lmul_bad_s = (vlmul != LMUL_1);
`endif
        vlmax     = VLEN_V >> shift_s;
        sew_bad_s = (vsew > SEW_64) || ((vsew == SEW_64) && !ENABLE_64_BIT);
        illegal   = rsvd_nz | sew_bad_s | lmul_bad_s | ratio_bad_s
                  | (vlmax == {VL_BITS{1'b0}});
    end

endmodule

// File: rtl/vcfg_unit.sv
// Vector configuration unit: executes vsetvli / vsetivli / vsetvl.
// Ports: clk, rst (synchronous, active high), bus (vcfg_unit_if.slave):
//   request handshake in, committed vl/vtype CSRs out, writeback handshake out.
// Flow: IDLE accepts -> CALC registers VLMAX/legality -> COMMIT writes CSRs and
// raises wb_valid/new_vl -> RESP holds writeback until wb_ready.
// Macro RVV_LMUL_EN enables non-unit LMUL (see vlmax_calc).
module vcfg_unit
    import rvv_cfg_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int VLEN          = 16384,
    parameter int VL_BITS       = $clog2(VLEN) + 1,
    parameter bit ENABLE_64_BIT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    vcfg_unit_if.slave bus
);

    state_e             state_r, next_state_s;
    logic               accept_s, commit_s;
    logic [1:0]         avl_mode_r;
    logic [XLEN-1:0]    avl_r;
    logic [XLEN-2:0]    vtype_r;      // top bit (vill position) is ignored
    logic [VL_BITS-1:0] vlmax_s, vlmax_r;
    logic               illegal_s, illegal_r;
    logic [VL_BITS-1:0] vl_new_s;
    logic               ill_new_s;
    logic [VL_BITS-1:0] vl_r;
    logic [2:0]         vsew_r, vlmul_r;
    logic               vta_r, vma_r, vill_r, new_vl_r, wb_valid_r;
    logic [XLEN-1:0]    wb_data_r;

    vlmax_calc #(
        .VLEN          (VLEN),
        .VL_BITS       (VL_BITS),
        .ENABLE_64_BIT (ENABLE_64_BIT)
    ) u_vlmax (
        .vsew    (vtype_r[VTYPE_VSEW_LSB +: 3]),
        .vlmul   (vtype_r[VTYPE_VLMUL_LSB +: 3]),
        .rsvd_nz (|vtype_r[XLEN-2:VTYPE_RSVD_LSB]),
        .vlmax   (vlmax_s),
        .illegal (illegal_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next state; flush only matters before the commit edge
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        commit_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    next_state_s = ST_CALC;
                    accept_s     = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (bus.flush) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (bus.flush) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                    commit_s     = 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.wb_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // New vl selection; AVL is compared at full XLEN so large AVLs saturate
    always_comb begin
        vl_new_s  = {VL_BITS{1'b0}};
        ill_new_s = illegal_r;
        if (illegal_r) begin
            vl_new_s = {VL_BITS{1'b0}};
        end else if (avl_mode_r[AVL_KEEP_BIT]) begin
            // Keeping vl is only legal if it still fits the new VLMAX.
            if (vl_r > vlmax_r) begin
                ill_new_s = 1'b1;
                vl_new_s  = {VL_BITS{1'b0}};
            end else begin
                vl_new_s = vl_r;
            end
        end else if (avl_mode_r == AVL_USE_MAX) begin
            vl_new_s = vlmax_r;
        end else if (avl_r < {{(XLEN-VL_BITS){1'b0}}, vlmax_r}) begin
            vl_new_s = avl_r[VL_BITS-1:0];
        end else begin
            vl_new_s = vlmax_r;
        end
    end

    // Request capture, VLMAX pipeline register, CSR commit and writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            avl_mode_r <= 2'b00;
            avl_r      <= {XLEN{1'b0}};
            vtype_r    <= {(XLEN-1){1'b0}};
            vlmax_r    <= {VL_BITS{1'b0}};
            illegal_r  <= 1'b0;
            vl_r       <= {VL_BITS{1'b0}};
            vsew_r     <= 3'd0;
            vlmul_r    <= 3'd0;
            vta_r      <= 1'b0;
            vma_r      <= 1'b0;
            vill_r     <= 1'b1;
            new_vl_r   <= 1'b0;
            wb_valid_r <= 1'b0;
            wb_data_r  <= {XLEN{1'b0}};
        end else begin
            new_vl_r <= 1'b0;
            if (accept_s) begin
                // vsetivli always takes its AVL from the zero-extended uimm.
                avl_mode_r <= (bus.cfg_type == CFG_VSETIVLI) ? AVL_USE_IN : bus.avl_mode;
                avl_r      <= bus.avl_in;
                vtype_r    <= bus.vtype_in[XLEN-2:0];
            end
            if (state_r == ST_CALC) begin
                vlmax_r   <= vlmax_s;
                illegal_r <= illegal_s;
            end
            if (commit_s) begin
                vl_r       <= vl_new_s;
                vill_r     <= ill_new_s;
                vsew_r     <= ill_new_s ? 3'd0 : vtype_r[VTYPE_VSEW_LSB +: 3];
                vlmul_r    <= ill_new_s ? 3'd0 : vtype_r[VTYPE_VLMUL_LSB +: 3];
                vta_r      <= ill_new_s ? 1'b0 : vtype_r[VTYPE_VTA_BIT];
                vma_r      <= ill_new_s ? 1'b0 : vtype_r[VTYPE_VMA_BIT];
                new_vl_r   <= 1'b1;
                wb_valid_r <= 1'b1;
                wb_data_r  <= {{(XLEN-VL_BITS){1'b0}}, vl_new_s};
            end else if ((state_r == ST_RESP) && bus.wb_ready) begin
                wb_valid_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready = (state_r == ST_IDLE) & ~rst;
    assign bus.vl       = vl_r;
    assign bus.vsew     = vsew_r;
    assign bus.vlmul    = vlmul_r;
    assign bus.vta      = vta_r;
    assign bus.vma      = vma_r;
    assign bus.vill     = vill_r;
    assign bus.new_vl   = new_vl_r;
    assign bus.wb_valid = wb_valid_r;
    assign bus.wb_data  = wb_data_r;

endmodule

// File: tb/tb_vcfg_unit.sv
// Directed self-checking bench for vcfg_unit (VLEN=16384, XLEN=32).
// Expectations that depend on RVV_LMUL_EN are selected from the macro.
module tb_vcfg_unit;
    import rvv_cfg_pkg::*;

    localparam int XLEN    = 32;
    localparam int VL_BITS = 15;
`ifdef RVV_LMUL_EN
    localparam bit LMUL_EN = 1'b1;
`else
    localparam bit LMUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vcfg_unit_if #(.XLEN(XLEN), .VL_BITS(VL_BITS)) bus ();

    vcfg_unit #(
        .XLEN(XLEN), .VLEN(16384), .VL_BITS(VL_BITS), .ENABLE_64_BIT(1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Present one request, bounded wait for in_ready; returns one negedge after accept.
    task automatic issue(input logic [1:0] ct, input logic [1:0] md,
                         input logic [31:0] avl, input logic [31:0] vt);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: in_ready=%b required 1", bus.in_ready);
        end
        bus.cfg_type = ct;
        bus.avl_mode = md;
        bus.avl_in   = avl;
        bus.vtype_in = vt;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Bounded wait until wb_valid is seen at a negedge.
    task automatic wait_wb();
        int n;
        n = 0;
        while (!bus.wb_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_wb: wb_valid=%b required 1", bus.wb_valid);
        end
    endtask

    task automatic ack();
        bus.wb_ready = 1'b1;
        @(negedge clk);
        bus.wb_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.flush = 1'b0; bus.wb_ready = 1'b0;
        bus.cfg_type = 2'b00; bus.avl_mode = 2'b00;
        bus.avl_in = 32'd0; bus.vtype_in = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.vl, bus.vill, bus.vsew, bus.vlmul, bus.vta, bus.vma, bus.new_vl, bus.wb_valid}
            !== {15'd0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_csr: vl=%0d vill=%b vsew=%0d vlmul=%0d vta=%b vma=%b new_vl=%b wb_valid=%b want 0,1,0,0,0,0,0,0",
                     bus.vl, bus.vill, bus.vsew, bus.vlmul, bus.vta, bus.vma, bus.new_vl, bus.wb_valid);
        end
        checks++;
        if (bus.wb_data !== 32'd0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_wb: wb_data=%0d in_ready=%b want 0,1", bus.wb_data, bus.in_ready);
        end
    endtask

    task automatic test_basic();
        issue(2'b00, 2'b00, 32'd100, 32'h0000_00C0);
        checks++;
        if (bus.wb_valid !== 1'b0 || bus.vill !== 1'b1) begin
            errors++; $display("FAIL lat_calc: wb_valid=%b vill=%b want 0,1", bus.wb_valid, bus.vill);
        end
        @(negedge clk);
        checks++;
        if (bus.wb_valid !== 1'b0 || bus.new_vl !== 1'b0) begin
            errors++; $display("FAIL lat_commit: wb_valid=%b new_vl=%b want 0,0", bus.wb_valid, bus.new_vl);
        end
        @(negedge clk);
        checks++;
        if ({bus.new_vl, bus.wb_valid, bus.vl, bus.vill, bus.vta, bus.vma, bus.vsew}
            !== {1'b1, 1'b1, 15'd100, 1'b0, 1'b1, 1'b1, 3'd0} || bus.wb_data !== 32'd100) begin
            errors++;
            $display("FAIL basic: new_vl=%b wb_valid=%b vl=%0d vill=%b vta=%b vma=%b vsew=%0d wb_data=%0d want 1,1,100,0,1,1,0,100",
                     bus.new_vl, bus.wb_valid, bus.vl, bus.vill, bus.vta, bus.vma, bus.vsew, bus.wb_data);
        end
        ack();
        checks++;
        if (bus.new_vl !== 1'b0 || bus.in_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin
            errors++; $display("FAIL basic_done: new_vl=%b in_ready=%b wb_valid=%b want 0,1,0",
                               bus.new_vl, bus.in_ready, bus.wb_valid);
        end
    endtask

    task automatic test_vlmax();
        logic [14:0] exp_vl;
        // sew32 lmul4, AVL=VLMAX -> 16384/32*4 = 2048
        exp_vl = LMUL_EN ? 15'd2048 : 15'd0;
        issue(2'b00, 2'b01, 32'd0, 32'h0000_0012);
        wait_wb();
        checks++;
        if (bus.vl !== exp_vl || bus.vill !== !LMUL_EN || bus.wb_data !== {17'd0, exp_vl}) begin
            errors++; $display("FAIL vlmax_lmul4: vl=%0d vill=%b wb_data=%0d want %0d,%b",
                               bus.vl, bus.vill, bus.wb_data, exp_vl, !LMUL_EN);
        end
        ack();
        // sew32 lmul1 -> 512 in every build
        issue(2'b00, 2'b01, 32'd0, 32'h0000_0010);
        wait_wb();
        checks++;
        if (bus.vl !== 15'd512 || bus.vill !== 1'b0 || bus.vsew !== 3'd2) begin
            errors++; $display("FAIL vlmax_lmul1: vl=%0d vill=%b vsew=%0d want 512,0,2", bus.vl, bus.vill, bus.vsew);
        end
        ack();
        // sew64 lmul1/8 violates LMUL >= SEW/ELEN
        issue(2'b00, 2'b01, 32'd0, 32'h0000_001D);
        wait_wb();
        checks++;
        if ({bus.vill, bus.vl, bus.vsew, bus.vlmul} !== {1'b1, 15'd0, 3'd0, 3'd0}) begin
            errors++; $display("FAIL sew64_frac: vill=%b vl=%0d vsew=%0d vlmul=%0d want 1,0,0,0",
                               bus.vill, bus.vl, bus.vsew, bus.vlmul);
        end
        ack();
    endtask

    task automatic test_ivli();
        issue(2'b11, 2'b00, 32'd0, 32'h0000_0008);
        wait_wb();
        checks++;
        if (bus.vl !== 15'd0 || bus.vill !== 1'b0 || bus.vsew !== 3'd1) begin
            errors++; $display("FAIL ivli_zero: vl=%0d vill=%b vsew=%0d want 0,0,1", bus.vl, bus.vill, bus.vsew);
        end
        ack();
        issue(2'b11, 2'b00, 32'd5, 32'h0000_0100);
        wait_wb();
        checks++;
        if (bus.vl !== 15'd0 || bus.vill !== 1'b1 || bus.wb_data !== 32'd0) begin
            errors++; $display("FAIL rsvd_bit8: vl=%0d vill=%b wb_data=%0d want 0,1,0", bus.vl, bus.vill, bus.wb_data);
        end
        ack();
        // vtype bit 31 is not a reserved bit
        issue(2'b10, 2'b00, 32'd7, 32'h8000_0000);
        wait_wb();
        checks++;
        if (bus.vl !== 15'd7 || bus.vill !== 1'b0) begin
            errors++; $display("FAIL vtype_bit31: vl=%0d vill=%b want 7,0", bus.vl, bus.vill);
        end
        ack();
        // AVL of 2^15 and all-ones saturate to VLMAX=2048 (sew8 lmul1)
        issue(2'b00, 2'b00, 32'h0000_8000, 32'h0000_0000);
        wait_wb();
        checks++;
        if (bus.vl !== 15'd2048) begin
            errors++; $display("FAIL sat_2p15: vl=%0d want 2048", bus.vl);
        end
        ack();
        issue(2'b00, 2'b00, 32'hFFFF_FFFF, 32'h0000_0000);
        wait_wb();
        checks++;
        if (bus.vl !== 15'd2048 || bus.wb_data !== 32'd2048) begin
            errors++; $display("FAIL sat_max: vl=%0d wb_data=%0d want 2048", bus.vl, bus.wb_data);
        end
        ack();
    endtask

    task automatic test_keep();
        issue(2'b00, 2'b00, 32'd512, 32'h0000_0000);
        wait_wb();
        checks++;
        if (bus.vl !== 15'd512) begin
            errors++; $display("FAIL keep_setup: vl=%0d want 512", bus.vl);
        end
        ack();
        // sew64 lmul1 -> VLMAX 256 < 512
        issue(2'b00, 2'b10, 32'd0, 32'h0000_0018);
        wait_wb();
        checks++;
        if (bus.vill !== 1'b1 || bus.vl !== 15'd0) begin
            errors++; $display("FAIL keep_shrink: vill=%b vl=%0d want 1,0", bus.vill, bus.vl);
        end
        ack();
        issue(2'b00, 2'b00, 32'd512, 32'h0000_0000);
        wait_wb();
        ack();
        issue(2'b00, 2'b11, 32'd0, 32'h0000_0008);
        wait_wb();
        checks++;
        if (bus.vl !== 15'd512 || bus.vill !== 1'b0 || bus.vsew !== 3'd1 || bus.wb_data !== 32'd512) begin
            errors++; $display("FAIL keep_ok: vl=%0d vill=%b vsew=%0d wb_data=%0d want 512,0,1,512",
                               bus.vl, bus.vill, bus.vsew, bus.wb_data);
        end
        ack();
    endtask

    task automatic test_backpressure();
        issue(2'b00, 2'b00, 32'd77, 32'h0000_0008);
        wait_wb();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'd77 || bus.in_ready !== 1'b0
                || bus.new_vl !== (i == 0)) begin
                errors++; $display("FAIL bp_hold%0d: wb_valid=%b wb_data=%0d in_ready=%b new_vl=%b want 1,77,0,%b",
                                   i, bus.wb_valid, bus.wb_data, bus.in_ready, bus.new_vl, (i == 0));
            end
            @(negedge clk);
        end
        ack();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: in_ready=%b wb_valid=%b want 1,0", bus.in_ready, bus.wb_valid);
        end
    endtask

    task automatic test_flush();
        // CSR state from the previous test: vl=77, vsew=1
        for (int d = 0; d < 2; d++) begin
            issue(2'b00, 2'b00, 32'd33, 32'h0000_0010);
            if (d == 1) @(negedge clk);
            bus.flush = 1'b1;
            @(negedge clk);
            bus.flush = 1'b0;
            checks++;
            if (bus.in_ready !== 1'b1 || bus.vl !== 15'd77 || bus.vsew !== 3'd1
                || bus.wb_valid !== 1'b0 || bus.new_vl !== 1'b0) begin
                errors++; $display("FAIL flush%0d: in_ready=%b vl=%0d vsew=%0d wb_valid=%b new_vl=%b want 1,77,1,0,0",
                                   d, bus.in_ready, bus.vl, bus.vsew, bus.wb_valid, bus.new_vl);
            end
            repeat (2) @(negedge clk);
            checks++;
            if (bus.wb_valid !== 1'b0 || bus.vl !== 15'd77) begin
                errors++; $display("FAIL flush%0d_late: wb_valid=%b vl=%0d want 0,77", d, bus.wb_valid, bus.vl);
            end
        end
        // flush during RESP has no effect
        issue(2'b00, 2'b00, 32'd33, 32'h0000_0010);
        wait_wb();
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        checks++;
        if (bus.wb_valid !== 1'b1 || bus.vl !== 15'd33) begin
            errors++; $display("FAIL flush_resp: wb_valid=%b vl=%0d want 1,33", bus.wb_valid, bus.vl);
        end
        ack();
    endtask

    task automatic test_rst_mid();
        issue(2'b00, 2'b00, 32'd9, 32'h0000_0000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.vl !== 15'd0 || bus.vill !== 1'b1 || bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid: vl=%0d vill=%b wb_valid=%b in_ready=%b want 0,1,0,1",
                               bus.vl, bus.vill, bus.wb_valid, bus.in_ready);
        end
    endtask

    task automatic test_lmul_cfg();
        // lmul2 sew8: 4096 with full LMUL range, illegal otherwise
        issue(2'b00, 2'b00, 32'd10, 32'h0000_0001);
        wait_wb();
        checks++;
        if (bus.vl !== (LMUL_EN ? 15'd10 : 15'd0) || bus.vill !== !LMUL_EN) begin
            errors++; $display("FAIL lmul2: vl=%0d vill=%b want %0d,%b",
                               bus.vl, bus.vill, (LMUL_EN ? 10 : 0), !LMUL_EN);
        end
        ack();
        issue(2'b00, 2'b00, 32'd5000, 32'h0000_0008);
        wait_wb();
        checks++;
        if (bus.vl !== 15'd1024 || bus.vill !== 1'b0) begin
            errors++; $display("FAIL sew16_sat: vl=%0d vill=%b want 1024,0", bus.vl, bus.vill);
        end
        ack();
        issue(2'b00, 2'b00, 32'd10, 32'h0000_0004);
        wait_wb();
        checks++;
        if (bus.vill !== 1'b1 || bus.vl !== 15'd0) begin
            errors++; $display("FAIL lmul_rsvd: vill=%b vl=%0d want 1,0", bus.vill, bus.vl);
        end
        ack();
    endtask

    task automatic test_back_to_back();
        bus.wb_ready = 1'b1;
        issue(2'b00, 2'b00, 32'd3, 32'h0000_0000);
        wait_wb();
        checks++;
        if (bus.vl !== 15'd3) begin
            errors++; $display("FAIL b2b_first: vl=%0d want 3", bus.vl);
        end
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_ready: in_ready=%b wb_valid=%b want 1,0", bus.in_ready, bus.wb_valid);
        end
        issue(2'b00, 2'b00, 32'd4, 32'h0000_0000);
        wait_wb();
        checks++;
        if (bus.vl !== 15'd4 || bus.wb_data !== 32'd4) begin
            errors++; $display("FAIL b2b_second: vl=%0d wb_data=%0d want 4", bus.vl, bus.wb_data);
        end
        @(negedge clk);
        bus.wb_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vlmax();
        test_ivli();
        test_keep();
        test_backpressure();
        test_flush();
        test_rst_mid();
        test_lmul_cfg();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
